// File: rtl/boot_mon_pkg.sv
// Shared types and board defaults for the target boot-time monitor.
package boot_mon_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RST = 2'd1,
        HOLD     = 2'd2,
        COUNT    = 2'd3
    } state_e;

    // 12 MHz board clock: one second of boot budget.
    localparam int          DEF_CNT_W   = 24;
    localparam int unsigned DEF_TIMEOUT = 32'd12_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous pin followed by a
// polarity-selectable single-edge detector.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pin_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= {SYNC_STAGES{~ACTIVE_HIGH}};
            last_q <= ~ACTIVE_HIGH;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = ACTIVE_HIGH ? (sync_q[SYNC_STAGES-1] & ~last_q)
                                : (~sync_q[SYNC_STAGES-1] & last_q);

endmodule

// File: rtl/boot_monitor.sv
// Measures cycles from target reset release to its first "alive" edge,
// with timeout and bounded auto-retry into the reset driver.
module boot_monitor
    import boot_mon_pkg::*;
#(
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int          SYNC_STAGES = 2,
    parameter bit          ALIVE_HIGH  = 1'b1,
    parameter int          MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             clear,
    input  logic             reset_line,
    input  logic             target_pin,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic             valid,
    output logic [CNT_W-1:0] boot_cycles,
    output logic             retry_req,
    output logic [1:0]       retry_cnt
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("boot_monitor: SYNC_STAGES must be at least 2");
    end
    if ((64'(TIMEOUT) >> CNT_W) != 64'd0) begin : g_bad_timeout
        $error("boot_monitor: TIMEOUT does not fit in CNT_W bits");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_retry
        $error("boot_monitor: MAX_RETRY must be 0..3");
    end

    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [1:0]       MAXR_VAL = 2'(MAX_RETRY);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] boot_q;
    logic [1:0]       retry_cnt_q;
    logic             busy_q, done_q, to_q, valid_q, retry_q;
    logic             alive;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .ACTIVE_HIGH (ALIVE_HIGH)
    ) u_sync (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .pin_i   (target_pin),
        .edge_o  (alive)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            boot_q      <= '0;
            retry_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            to_q        <= 1'b0;
            valid_q     <= 1'b0;
            retry_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            retry_q <= 1'b0;
            if (clear) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                boot_q  <= '0;
            end else if (arm) begin
                // A reset already in progress skips straight to HOLD.
                state_q     <= reset_line ? HOLD : WAIT_RST;
                busy_q      <= 1'b1;
                valid_q     <= 1'b0;
                retry_cnt_q <= '0;
                cnt_q       <= '0;
            end else begin
                case (state_q)
                    IDLE: ;
                    WAIT_RST: begin
                        if (reset_line) state_q <= HOLD;
                    end
                    HOLD: begin
                        if (reset_line) begin
                            cnt_q <= '0;
                        end else begin
                            state_q <= COUNT;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    COUNT: begin
                        if (reset_line) begin
                            state_q <= HOLD;
                            cnt_q   <= '0;
                        end else if (alive) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            boot_q  <= cnt_q;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end else if (cnt_q == TO_VAL) begin
                            if (retry_cnt_q < MAXR_VAL) begin
                                state_q     <= WAIT_RST;
                                retry_q     <= 1'b1;
                                retry_cnt_q <= retry_cnt_q + 2'd1;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                to_q    <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timed_out   = to_q;
    assign valid       = valid_q;
    assign boot_cycles = boot_q;
    assign retry_req   = retry_q;
    assign retry_cnt   = retry_cnt_q;

endmodule

// File: tb/tb_boot_monitor.sv
// Scoreboard bench for boot_monitor: a rising-edge/retry instance and a
// falling-edge/no-retry instance share one clock and reset.
module tb_boot_monitor;

    localparam int CW = 24;
    localparam int K_DONE = 0, K_TO = 1, K_RETRY = 2;

    typedef struct {
        int unit;
        int kind;
        int boot;   // -1: not compared
        int vld;
        int rc;
        int bsy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arm = 1'b0, clear = 1'b0, rl = 1'b0, pin = 1'b0;
    logic arm0 = 1'b0, clear0 = 1'b0, rl0 = 1'b0, pin0 = 1'b1;

    logic          busy, done, tmo, vld, rreq;
    logic [CW-1:0] boot;
    logic [1:0]    rcnt;
    logic          busy0, done0, tmo0, vld0, rreq0;
    logic [CW-1:0] boot0;
    logic [1:0]    rcnt0;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    boot_monitor #(.CNT_W(CW), .TIMEOUT(100), .SYNC_STAGES(2),
                   .ALIVE_HIGH(1'b1), .MAX_RETRY(2)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear),
        .reset_line(rl), .target_pin(pin), .busy(busy), .done(done),
        .timed_out(tmo), .valid(vld), .boot_cycles(boot),
        .retry_req(rreq), .retry_cnt(rcnt));

    boot_monitor #(.CNT_W(CW), .TIMEOUT(100), .SYNC_STAGES(2),
                   .ALIVE_HIGH(1'b0), .MAX_RETRY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .arm(arm0), .clear(clear0),
        .reset_line(rl0), .target_pin(pin0), .busy(busy0), .done(done0),
        .timed_out(tmo0), .valid(vld0), .boot_cycles(boot0),
        .retry_req(rreq0), .retry_cnt(rcnt0));

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, expv, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int u, input int k, input int b, input int v,
                        input int r, input int bs);
        exp_t e;
        e = '{unit: u, kind: k, boot: b, vld: v, rc: r, bsy: bs};
        q.push_back(e);
    endtask

    task automatic observe(input int u, input int k, input logic v,
                           input logic [CW-1:0] b, input logic [1:0] r,
                           input logic bs);
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected_pulse_kind", k, -1);
        end else begin
            e = q.pop_front();
            chk("evt_unit", u, e.unit);
            chk("evt_kind", k, e.kind);
            if (e.boot >= 0) chk("evt_boot_cycles", int'(b), e.boot);
            chk("evt_valid", int'(v), e.vld);
            chk("evt_retry_cnt", int'(r), e.rc);
            chk("evt_busy", int'(bs), e.bsy);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done)  observe(0, K_DONE,  vld, boot, rcnt, busy);
                if (tmo)   observe(0, K_TO,    vld, boot, rcnt, busy);
                if (rreq)  observe(0, K_RETRY, vld, boot, rcnt, busy);
                if (done0) observe(1, K_DONE,  vld0, boot0, rcnt0, busy0);
                if (tmo0)  observe(1, K_TO,    vld0, boot0, rcnt0, busy0);
                if (rreq0) observe(1, K_RETRY, vld0, boot0, rcnt0, busy0);
            end
        end
    end

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (q.size() != 0 && n < limit) begin
            tick(1);
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    // Returns cycles waited until a retry/timeout pulse of the unit shows.
    task automatic wait_pulse(input int u, input int limit, output int n);
        n = 0;
        while (n < limit && !(u == 0 ? (rreq | tmo) : (rreq0 | tmo0))) begin
            tick(1);
            n++;
        end
    endtask

    // Arms unit 0, pulses its reset line, and returns at the first COUNT cycle.
    task automatic start0(input int hold);
        arm = 1'b1; tick(1); arm = 1'b0;
        rl = 1'b1; tick(hold); rl = 1'b0; tick(1);
    endtask

    task automatic start1(input int hold);
        arm0 = 1'b1; tick(1); arm0 = 1'b0;
        rl0 = 1'b1; tick(hold); rl0 = 1'b0; tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_valid", vld, 0);
        chk("rst_boot", int'(boot), 0);
        chk("rst_retry_cnt", int'(rcnt), 0);
        chk("rst_pulses", int'({done, tmo, rreq}), 0);
        chk("rst_busy0", busy0, 0);
        rst_n = 1'b1;
        tick(2);

        // Nominal capture: pin rises 40 cycles into COUNT -> 43.
        arm = 1'b1; tick(1); arm = 1'b0;
        chk("arm_busy", busy, 1);
        rl = 1'b1; tick(10); rl = 1'b0; tick(1);
        tick(40); pin = 1'b1;
        push(0, K_DONE, 43, 1, 0, 0);
        drain("nominal_drain", 20);
        chk("nominal_valid", vld, 1);
        chk("nominal_boot", int'(boot), 43);
        pin = 1'b0; tick(5);

        // Timeout with two retries, then timed_out.
        arm = 1'b1; tick(1); arm = 1'b0;
        for (int r = 0; r < 3; r++) begin
            rl = 1'b1; tick(5); rl = 1'b0; tick(1);
            if (r < 2) push(0, K_RETRY, -1, 0, r + 1, 1);
            else       push(0, K_TO, -1, 0, 2, 0);
            wait_pulse(0, 150, n);
            chk("timeout_latency", n, 100);
            tick(1);
        end
        drain("timeout_drain", 10);
        chk("timeout_valid", vld, 0);
        chk("timeout_retry_cnt", int'(rcnt), 2);
        chk("timeout_busy", busy, 0);

        // Edge lands on the timeout cycle: done wins.
        start0(5);
        tick(97); pin = 1'b1;
        push(0, K_DONE, 100, 1, 0, 0);
        drain("edge_on_to_drain", 20);
        chk("edge_on_to_boot", int'(boot), 100);
        pin = 1'b0; tick(110);

        // External re-reset at count 30, not counted as retry.
        start0(5);
        tick(29); rl = 1'b1; tick(5);
        chk("rereset_busy", busy, 1);
        rl = 1'b0; tick(1);
        tick(20); pin = 1'b1;
        push(0, K_DONE, 23, 1, 0, 0);
        drain("rereset_drain", 20);
        chk("rereset_boot", int'(boot), 23);
        chk("rereset_retry_cnt", int'(rcnt), 0);
        pin = 1'b0; tick(5);

        // Clear in the same cycle the edge is detected.
        start0(5);
        tick(10); pin = 1'b1; tick(2);
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("clear_valid", vld, 0);
        chk("clear_busy", busy, 0);
        chk("clear_boot", int'(boot), 0);
        chk("clear_done", done, 0);
        tick(120);
        pin = 1'b0; tick(5);

        // rst_n during COUNT.
        start0(5);
        tick(10);
        chk("precount_busy", busy, 1);
        rst_n = 1'b0; tick(1);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", vld, 0);
        chk("midrst_outs", int'({done, tmo, rreq, rcnt}), 0);
        chk("midrst_boot", int'(boot), 0);
        rst_n = 1'b1; tick(2);

        // Falling-edge polarity, no retry.
        start1(5);
        tick(15); pin0 = 1'b0;
        push(1, K_DONE, 18, 1, 0, 0);
        drain("pol_drain", 20);
        chk("pol_boot", int'(boot0), 18);
        tick(5);
        start1(5);
        chk("pol_rearm_valid", vld0, 0);
        tick(10); pin0 = 1'b1;
        push(1, K_TO, -1, 0, 0, 0);
        wait_pulse(1, 150, n);
        chk("pol_timeout_latency", n, 90);
        drain("pol_to_drain", 10);
        chk("pol_to_valid", vld0, 0);
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
